counter_updown_nb: RTL and testbench

- Parametrised, registered up/down counter built around the N-bit incrementer/decrementer datapath.
- Adds over the combinational incrementer: clock, asynchronous reset, enable, direction, parallel load, synchronous clear, wrap or saturate mode, a registered carry/borrow pulse and a sticky overflow flag.
- Used as the general-purpose counter in the datapath library (program counters, event counters, timers).

---
 rtl/counter_updown_nb.sv | 74 +++++++
 tb/tb_counter_updown_nb.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/counter_updown_nb.sv
// Registered up/down counter with load, clear, wrap/saturate, carry pulse and sticky overflow.
// Latency: one clk edge to Q/Cout/OVF; TC is combinational from Q and up. No backpressure.
module counter_updown_nb #(
  parameter int          WIDTH    = 8,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] Q,
  output logic             Cout,
  output logic             OVF,
  output logic             TC
);

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);
  localparam logic [WIDTH:0]   ONE   = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   step;
  logic             boundary;

  // The extra MSB of the step result is the carry (up) or borrow (down).
  always_comb begin
    step = up ? ({1'b0, q_q} + ONE) : ({1'b0, q_q} - ONE);
    boundary = step[WIDTH];
  end

  always_comb begin
    q_d    = q_q;
    cout_d = 1'b0;
    ovf_d  = ovf_q;
    if (clr) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      q_d   = D;
      ovf_d = 1'b0;
    end else if (en) begin
      if (boundary) begin
        cout_d = 1'b1;
        ovf_d  = 1'b1;
        q_d    = SATURATE ? q_q : step[WIDTH-1:0];
      end else begin
        q_d = step[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= RST_Q;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Q    = q_q;
  assign Cout = cout_q;
  assign OVF  = ovf_q;
  assign TC   = up ? (&q_q) : ~(|q_q);

endmodule

// File: tb/tb_counter_updown_nb.sv
// Directed bench for counter_updown_nb: 8-bit wrap, 8-bit saturate and 4-bit wrap instances.
module tb_counter_updown_nb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit wrap instance
  logic       clr_w = 0, load_w = 0, en_w = 0, up_w = 0;
  logic [7:0] d_w = '0, q_w;
  logic       cout_w, ovf_w, tc_w;
  // 8-bit saturate instance
  logic       clr_s = 0, load_s = 0, en_s = 0, up_s = 0;
  logic [7:0] d_s = '0, q_s;
  logic       cout_s, ovf_s, tc_s;
  // 4-bit wrap instance
  logic       clr_n = 0, load_n = 0, en_n = 0, up_n = 0;
  logic [3:0] d_n = '0, q_n;
  logic       cout_n, ovf_n, tc_n;

  counter_updown_nb #(.WIDTH(8), .SATURATE(1'b0), .RST_VAL(0)) dut_w (
    .clk(clk), .rst(rst), .clr(clr_w), .load(load_w), .D(d_w), .en(en_w), .up(up_w),
    .Q(q_w), .Cout(cout_w), .OVF(ovf_w), .TC(tc_w));

  counter_updown_nb #(.WIDTH(8), .SATURATE(1'b1), .RST_VAL(0)) dut_s (
    .clk(clk), .rst(rst), .clr(clr_s), .load(load_s), .D(d_s), .en(en_s), .up(up_s),
    .Q(q_s), .Cout(cout_s), .OVF(ovf_s), .TC(tc_s));

  counter_updown_nb #(.WIDTH(4), .SATURATE(1'b0), .RST_VAL(0)) dut_n (
    .clk(clk), .rst(rst), .clr(clr_n), .load(load_n), .D(d_n), .en(en_n), .up(up_n),
    .Q(q_n), .Cout(cout_n), .OVF(ovf_n), .TC(tc_n));

  int n_assert = 0;
  int n_fail   = 0;
  int pulses   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_q", q_w, 8'h00);
    chk("rst_cout", cout_w, 0);
    chk("rst_ovf", ovf_w, 0);
    chk("rst_tc_down", tc_w, 1);
    tick();
    chk("rst_held_q", q_w, 8'h00);
    rst = 1'b0;

    // count to 8'h37, then reset asynchronously mid-cycle
    load_w = 1; d_w = 8'h35;
    tick();
    chk("load35", q_w, 8'h35);
    load_w = 0; en_w = 1; up_w = 1;
    tick();
    tick();
    chk("cnt37", q_w, 8'h37);
    rst = 1'b1;
    #1;
    chk("async_rst_q", q_w, 8'h00);
    chk("async_rst_cout", cout_w, 0);
    chk("async_rst_ovf", ovf_w, 0);
    tick();
    chk("rst_hold_edge_q", q_w, 8'h00);
    rst = 1'b0; en_w = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_q", q_w, 8'h00);
    end

    // increment wrap
    load_w = 1; d_w = 8'hFE;
    tick();
    chk("loadFE", q_w, 8'hFE);
    load_w = 0; en_w = 1; up_w = 1;
    tick();
    chk("inc_ff_q", q_w, 8'hFF);
    chk("inc_ff_tc", tc_w, 1);
    chk("inc_ff_cout", cout_w, 0);
    tick();
    chk("wrap_q", q_w, 8'h00);
    chk("wrap_cout", cout_w, 1);
    chk("wrap_ovf", ovf_w, 1);
    tick();
    chk("post_wrap_q", q_w, 8'h01);
    chk("post_wrap_cout", cout_w, 0);
    chk("post_wrap_ovf", ovf_w, 1);

    // load clears sticky overflow
    en_w = 0; load_w = 1; d_w = 8'h10;
    tick();
    chk("ovfclr_q", q_w, 8'h10);
    chk("ovfclr_ovf", ovf_w, 0);
    load_w = 0; en_w = 1; up_w = 0;
    tick();
    chk("dec_q", q_w, 8'h0F);

    // clr beats load beats en
    clr_w = 1; load_w = 1; d_w = 8'hAA; en_w = 1; up_w = 1;
    tick();
    chk("prio_clr_q", q_w, 8'h00);
    clr_w = 0;
    tick();
    chk("prio_load_q", q_w, 8'hAA);

    // decrement wrap from zero, then TC follows up without a clock
    clr_w = 1; load_w = 0;
    tick();
    clr_w = 0; en_w = 1; up_w = 0;
    tick();
    chk("dwrap_q", q_w, 8'hFF);
    chk("dwrap_cout", cout_w, 1);
    chk("dwrap_ovf", ovf_w, 1);
    en_w = 0;
    tick();
    chk("dwrap_hold_q", q_w, 8'hFF);
    chk("dwrap_cout_clr", cout_w, 0);
    chk("dwrap_ovf_sticky", ovf_w, 1);
    chk("tc_down_at_ff", tc_w, 0);
    up_w = 1;
    #1;
    chk("tc_up_at_ff", tc_w, 1);

    // decrement saturate
    load_s = 1; d_s = 8'h01;
    tick();
    load_s = 0; en_s = 1; up_s = 0;
    tick();
    chk("sat1_q", q_s, 8'h00);
    chk("sat1_cout", cout_s, 0);
    chk("sat1_ovf", ovf_s, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("satn_q", q_s, 8'h00);
      chk("satn_cout", cout_s, 1);
      chk("satn_ovf", ovf_s, 1);
    end

    // increment saturate at max
    en_s = 0; load_s = 1; d_s = 8'hFF;
    tick();
    chk("sat_load_ovf", ovf_s, 0);
    load_s = 0; en_s = 1; up_s = 1;
    tick();
    chk("satup_q", q_s, 8'hFF);
    chk("satup_cout", cout_s, 1);
    chk("satup_ovf", ovf_s, 1);
    en_s = 0;
    tick();
    chk("satup_cout_clr", cout_s, 0);

    // 4-bit sweep: 17 up counts from 0
    en_n = 1; up_n = 1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk("w4_q", q_n, 32'(i % 16));
      chk("w4_cout", cout_n, (i == 16) ? 1 : 0);
      if (cout_n) pulses++;
    end
    chk("w4_pulses", pulses, 1);
    en_n = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
